// File: rtl/param_counter.sv
// General-purpose event/interval counter: configurable width, modulo and direction,
// with synchronous load, wrap/saturate ends, prescaler, terminal-count pulse and sticky overflow.
module param_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int          PRESCALE  = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             overflow
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             step;
  logic             at_end;
  logic             end_event;
  logic [WIDTH-1:0] load_clamped;

  assign step         = enable && (psc_q == PSC_LAST);
  assign at_end       = up_down ? (cnt_q == MAX_VAL) : (cnt_q == '0);
  // A load in the same cycle swallows the step, so it cannot raise any flag either.
  assign end_event    = step && !load && at_end;
  assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

  // Prescaler next state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    psc_d = psc_q;
    if (load) begin
      psc_d = '0;
    end else if (enable) begin
      psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + 1'b1;
    end
  end

  // Count next state: explicit end compares keep non-power-of-two ranges exact.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (up_down) begin
        if (cnt_q != MAX_VAL)  cnt_d = cnt_q + 1'b1;
        else if (!SATURATE)    cnt_d = '0;
      end else begin
        if (cnt_q != '0)       cnt_d = cnt_q - 1'b1;
        else if (!SATURATE)    cnt_d = MAX_VAL;
      end
    end
  end

  // Flags: pulse tracks the end event; overflow set beats clear.
  always_comb begin
    tc_d  = end_event;
    ovf_d = end_event | (ovf_q & ~clear_flags);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      psc_q <= '0;
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign counter_out    = cnt_q;
  assign terminal_count = tc_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: wrap, prescaled and saturating instances
// driven from a shared stimulus sequence.
module tb_param_counter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset, enable, up_down, load, clear_flags;
  logic [W-1:0] load_value;

  logic [W-1:0] cnt_w, cnt_p, cnt_s;
  logic         tc_w, tc_p, tc_s;
  logic         ovf_w, ovf_p, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  param_counter #(.WIDTH(W), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags),
    .counter_out(cnt_w), .terminal_count(tc_w), .overflow(ovf_w));

  param_counter #(.WIDTH(W), .MAX_COUNT(9), .PRESCALE(3), .SATURATE(1'b0)) u_psc (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags),
    .counter_out(cnt_p), .terminal_count(tc_p), .overflow(ovf_p));

  param_counter #(.WIDTH(W), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_flags(clear_flags),
    .counter_out(cnt_s), .terminal_count(tc_s), .overflow(ovf_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; clear_flags = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  logic        en_p  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int          exp_p [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = '0; clear_flags = 1'b0;
    #2;

    // Reset state on all instances.
    do_reset();
    check("rst_cnt_w", cnt_w, 0); check("rst_tc_w", tc_w, 0); check("rst_ovf_w", ovf_w, 0);
    check("rst_cnt_p", cnt_p, 0); check("rst_cnt_s", cnt_s, 0); check("rst_ovf_s", ovf_s, 0);

    // Wrap up-count over a modulo-10 range.
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_cnt_%0d", i), cnt_w, i % 10);
      check($sformatf("up_tc_%0d", i), tc_w, (i == 10) ? 1 : 0);
      check($sformatf("up_ovf_%0d", i), ovf_w, (i >= 10) ? 1 : 0);
    end

    // Down-count from 0 wraps to MAX_COUNT with a pulse.
    do_reset();
    enable = 1'b1; up_down = 1'b0;
    tick(); check("dn_cnt_1", cnt_w, 9); check("dn_tc_1", tc_w, 1); check("dn_ovf_1", ovf_w, 1);
    tick(); check("dn_cnt_2", cnt_w, 8); check("dn_tc_2", tc_w, 0);
    tick(); check("dn_cnt_3", cnt_w, 7); check("dn_ovf_3", ovf_w, 1);
    enable = 1'b0; clear_flags = 1'b1;
    tick(); check("clr_ovf", ovf_w, 0); check("clr_cnt_hold", cnt_w, 7);
    clear_flags = 1'b0; load = 1'b1; load_value = 4'd0;
    tick(); check("ld0_cnt", cnt_w, 0); check("ld0_ovf", ovf_w, 0); check("ld0_tc", tc_w, 0);
    load = 1'b0; enable = 1'b1; clear_flags = 1'b1;
    tick(); check("clrset_cnt", cnt_w, 9); check("clrset_tc", tc_w, 1); check("clrset_ovf", ovf_w, 1);
    clear_flags = 1'b0; enable = 1'b0;
    tick(); check("clrset_tc_end", tc_w, 0); check("clrset_ovf_hold", ovf_w, 1);

    // Prescale by 3 with an enable gap.
    do_reset();
    up_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      enable = en_p[i];
      tick();
      check($sformatf("psc_cnt_%0d", i), cnt_p, exp_p[i]);
    end

    // Saturate: clamped load, then hold at MAX_COUNT with repeated pulses.
    do_reset();
    load = 1'b1; load_value = 4'd12;
    tick(); check("sat_ld_cnt", cnt_s, 9); check("sat_ld_tc", tc_s, 0); check("sat_ld_ovf", ovf_s, 0);
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), cnt_s, 9);
      check($sformatf("sat_tc_%0d", i), tc_s, 1);
      check($sformatf("sat_ovf_%0d", i), ovf_s, 1);
    end
    load = 1'b1; load_value = 4'd0; enable = 1'b0;
    tick(); check("sat_ld0_tc", tc_s, 0);
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    tick(); check("sat_dn_cnt", cnt_s, 0); check("sat_dn_tc", tc_s, 1);

    // Load beats a pending step and restarts the prescaler.
    do_reset();
    enable = 1'b1; up_down = 1'b1;
    tick(); tick();
    check("pre_ld_cnt_p", cnt_p, 0); check("pre_ld_cnt_w", cnt_w, 2);
    load = 1'b1; load_value = 4'd5;
    tick(); check("ld_step_p", cnt_p, 5); check("ld_step_w", cnt_w, 5); check("ld_step_tc", tc_w, 0);
    load = 1'b0;
    tick(); check("ld_psc1_p", cnt_p, 5); check("ld_next_w", cnt_w, 6);
    tick(); check("ld_psc2_p", cnt_p, 5);
    tick(); check("ld_psc3_p", cnt_p, 6);

    // Reset mid-count with overflow set.
    do_reset();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("mid_cnt", cnt_w, 7); check("mid_ovf", ovf_w, 1);
    reset = 1'b1;
    tick(); check("mid_rst_cnt", cnt_w, 0); check("mid_rst_ovf", ovf_w, 0); check("mid_rst_tc", tc_w, 0);
    reset = 1'b0;
    tick(); check("post_rst_cnt", cnt_w, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
